// File: rtl/counter_pkg.sv
// Shared encodings for the modulo counter: direction and boundary-mode constants.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // True when the parameter set describes a representable, non-empty step range.
    function automatic bit params_legal(input int unsigned width, input int unsigned step,
                                        input int unsigned max_val, input int unsigned mode);
        longint unsigned max_repr;
        max_repr = (64'd1 << width) - 64'd1;
        return (width >= 1) && (width <= 31) && (step >= 1) && (step <= max_val) &&
               (longint'(max_val) <= max_repr) && ((mode == MODE_WRAP) || (mode == MODE_SAT));
    endfunction

endpackage

// File: rtl/mod_step.sv
// Combinational next-value and boundary-crossing logic for mod_counter.
module mod_step
    import counter_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned STEP          = 1,
    parameter int unsigned MAX_VAL       = 2**COUNTER_WIDTH - 1,
    parameter int unsigned SATURATE      = MODE_WRAP
) (
    input  logic [COUNTER_WIDTH-1:0] count,
    input  logic                     up,
    output logic [COUNTER_WIDTH-1:0] next_val,
    output logic                     crossing
);

    // One extra bit so count+STEP and count+(MAX_VAL+1) never truncate.
    localparam int unsigned ExtWidth = COUNTER_WIDTH + 1;
    localparam logic [ExtWidth-1:0] MaxExt  = ExtWidth'(MAX_VAL);
    localparam logic [ExtWidth-1:0] StepExt = ExtWidth'(STEP);
    localparam logic [ExtWidth-1:0] ModExt  = MaxExt + ExtWidth'(1);

    logic [ExtWidth-1:0] count_ext;
    logic [ExtWidth-1:0] sum;

    always_comb begin
        count_ext = {1'b0, count};
        sum       = count_ext + StepExt;
        next_val  = count;
        crossing  = 1'b0;
        if (up == DIR_UP) begin
            if (sum > MaxExt) begin
                crossing = 1'b1;
                if (SATURATE == MODE_SAT) begin
                    next_val = COUNTER_WIDTH'(MaxExt);
                end else begin
                    next_val = COUNTER_WIDTH'(sum - ModExt);
                end
            end else begin
                next_val = COUNTER_WIDTH'(sum);
            end
        end else begin
            if (count_ext < StepExt) begin
                crossing = 1'b1;
                if (SATURATE == MODE_SAT) begin
                    next_val = '0;
                end else begin
                    next_val = COUNTER_WIDTH'(count_ext + ModExt - StepExt);
                end
            end else begin
                next_val = COUNTER_WIDTH'(count_ext - StepExt);
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with wrap or saturate bounds and a one-cycle overflow pulse.
// Define MOD_COUNTER_STICKY_EN to add the ovf_sticky output and its register.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned STEP          = 1,
    parameter int unsigned MAX_VAL       = 2**COUNTER_WIDTH - 1,
    parameter int unsigned SATURATE      = MODE_WRAP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_val,
    input  logic                     cnt,
    input  logic                     up,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     tc,
    output logic                     ovf
`ifdef MOD_COUNTER_STICKY_EN
    ,
    output logic                     ovf_sticky
`endif
);

    if (!params_legal(COUNTER_WIDTH, STEP, MAX_VAL, SATURATE)) begin : g_param_check
        $error("mod_counter: illegal parameters (need 1 <= STEP <= MAX_VAL < 2**COUNTER_WIDTH)");
    end

    localparam logic [COUNTER_WIDTH-1:0] MaxW = COUNTER_WIDTH'(MAX_VAL);

    logic [COUNTER_WIDTH-1:0] count_d, count_q;
    logic                     ovf_d, ovf_q;
    logic [COUNTER_WIDTH-1:0] step_val;
    logic                     step_cross;

    mod_step #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .STEP          (STEP),
        .MAX_VAL       (MAX_VAL),
        .SATURATE      (SATURATE)
    ) u_step (
        .count    (count_q),
        .up       (up),
        .next_val (step_val),
        .crossing (step_cross)
    );

    // clr beats load beats cnt; only an accepted count step can raise ovf.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MaxW) ? MaxW : load_val;
        end else if (cnt) begin
            count_d = step_val;
            ovf_d   = step_cross;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MOD_COUNTER_STICKY_EN
    logic sticky_d, sticky_q;

    always_comb begin
        sticky_d = sticky_q;
        if (clr) begin
            sticky_d = 1'b0;
        end else if (ovf_d) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = (up == DIR_DOWN) ? (count_q == '0) : (count_q == MaxW);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: wrap and saturate instances against an arithmetic model.
module tb_mod_counter;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int STP  = 3;
    localparam int MODV = MAXV + 1;

    logic         clk;
    logic         reset;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         cnt;
    logic         up;

    logic [W-1:0] count_w, count_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;
`ifdef MOD_COUNTER_STICKY_EN
    logic         sticky_w, sticky_s;
`endif

    int passed = 0;
    int total  = 0;

    // Reference state: count, ovf pulse, sticky flag for each instance.
    int mc_w, mc_s;
    bit mo_w, mo_s, ms_w, ms_s;

    mod_counter #(
        .COUNTER_WIDTH (W),
        .STEP          (STP),
        .MAX_VAL       (MAXV),
        .SATURATE      (0)
    ) u_wrap (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .up       (up),
        .count    (count_w),
        .tc       (tc_w),
        .ovf      (ovf_w)
`ifdef MOD_COUNTER_STICKY_EN
        ,
        .ovf_sticky (sticky_w)
`endif
    );

    mod_counter #(
        .COUNTER_WIDTH (W),
        .STEP          (STP),
        .MAX_VAL       (MAXV),
        .SATURATE      (1)
    ) u_sat (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .up       (up),
        .count    (count_s),
        .tc       (tc_s),
        .ovf      (ovf_s)
`ifdef MOD_COUNTER_STICKY_EN
        ,
        .ovf_sticky (sticky_s)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Plain-arithmetic model of one edge for the current inputs.
    task automatic ref_edge(input bit sat, input int c_in, output int c_out, output bit o_out);
        int sum;
        c_out = c_in;
        o_out = 1'b0;
        if (clr) begin
            c_out = 0;
        end else if (load) begin
            c_out = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        end else if (cnt) begin
            if (up) begin
                sum = c_in + STP;
                o_out = (sum > MAXV);
                c_out = !o_out ? sum : (sat ? MAXV : sum % MODV);
            end else begin
                o_out = (c_in < STP);
                c_out = !o_out ? c_in - STP : (sat ? 0 : (c_in - STP + MODV) % MODV);
            end
        end
    endtask

    task automatic model_reset();
        mc_w = 0; mc_s = 0;
        mo_w = 1'b0; mo_s = 1'b0;
        ms_w = 1'b0; ms_s = 1'b0;
    endtask

    task automatic tick();
        int nw, ns;
        bit ow, os;
        ref_edge(1'b0, mc_w, nw, ow);
        ref_edge(1'b1, mc_s, ns, os);
        @(posedge clk);
        ms_w = clr ? 1'b0 : (ms_w | ow);
        ms_s = clr ? 1'b0 : (ms_s | os);
        mc_w = nw; mo_w = ow;
        mc_s = ns; mo_s = os;
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count_w"}, 32'(count_w), 32'(mc_w));
        check({tag, "_ovf_w"},   32'(ovf_w),   32'(mo_w));
        check({tag, "_tc_w"},    32'(tc_w),    32'(up ? (mc_w == MAXV) : (mc_w == 0)));
        check({tag, "_count_s"}, 32'(count_s), 32'(mc_s));
        check({tag, "_ovf_s"},   32'(ovf_s),   32'(mo_s));
        check({tag, "_tc_s"},    32'(tc_s),    32'(up ? (mc_s == MAXV) : (mc_s == 0)));
`ifdef MOD_COUNTER_STICKY_EN
        check({tag, "_sticky_w"}, 32'(sticky_w), 32'(ms_w));
        check({tag, "_sticky_s"}, 32'(sticky_s), 32'(ms_s));
`endif
    endtask

    task automatic set_in(input logic c, input logic l, input int lv, input logic e, input logic u);
        clr = c; load = l; load_val = W'(lv); cnt = e; up = u;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        #3;
        check_all("reset");
        check("reset_count", 32'(count_w), 32'd0);
        #1 reset = 1'b0;

        // Wrap up on the wrap instance, saturating hold on the other.
        set_in(1'b0, 1'b1, 8, 1'b0, 1'b1);
        tick(); check_all("load8");
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick(); check_all("up1");
        check("wrap_up_c1", 32'(count_w), 32'd1);
        check("wrap_up_o1", 32'(ovf_w), 32'd1);
        check("sat_up_c1", 32'(count_s), 32'd9);
        tick(); check_all("up2");
        check("wrap_up_c2", 32'(count_w), 32'd4);
        check("wrap_up_o2", 32'(ovf_w), 32'd0);
        check("sat_up_o2", 32'(ovf_s), 32'd1);
        check("sat_tc", 32'(tc_s), 32'd1);

        // Wrap down from 1.
        set_in(1'b0, 1'b1, 1, 1'b0, 1'b0);
        tick(); check_all("load1");
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick(); check_all("down1");
        check("wrap_dn_c", 32'(count_w), 32'd8);
        check("wrap_dn_o", 32'(ovf_w), 32'd1);
        check("sat_dn_tc", 32'(tc_s), 32'd1);
        set_in(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick(); check_all("clr0");
        check("wrap_tc_zero", 32'(tc_w), 32'd1);

        // Priority clr > load > cnt, and load clamping.
        set_in(1'b1, 1'b1, 5, 1'b1, 1'b1);
        tick(); check_all("prio_clr");
        check("prio_clr_c", 32'(count_w), 32'd0);
        set_in(1'b0, 1'b1, 5, 1'b1, 1'b1);
        tick(); check_all("prio_load");
        check("prio_load_c", 32'(count_w), 32'd5);
        check("prio_load_o", 32'(ovf_w), 32'd0);
        set_in(1'b0, 1'b1, 15, 1'b1, 1'b1);
        tick(); check_all("load_clamp");
        check("load_clamp_c", 32'(count_s), 32'd9);

        // Asynchronous reset between edges at count 7 with ovf high.
        set_in(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick(); check_all("pre_rst");
        check("pre_rst_c", 32'(count_w), 32'd7);
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_c", 32'(count_w), 32'd0);
        check("async_rst_o", 32'(ovf_s), 32'd0);
        #1 reset = 1'b0;
        tick(); check_all("post_rst");
        check("post_rst_c", 32'(count_w), 32'd3);

`ifdef MOD_COUNTER_STICKY_EN
        set_in(1'b0, 1'b1, 9, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick(); check_all("stk_set");
        check("stk_set_w", 32'(sticky_w), 32'd1);
        set_in(1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stk_hold_w", 32'(sticky_w), 32'd1);
        end
        set_in(1'b1, 1'b0, 0, 1'b0, 1'b1);
        tick(); check_all("stk_clr");
        check("stk_clr_w", 32'(sticky_w), 32'd0);
`endif

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            clr      = ($urandom_range(15) == 0);
            load     = ($urandom_range(7) == 0);
            cnt      = ($urandom_range(3) != 0);
            up       = 1'($urandom_range(1));
            load_val = W'($urandom_range(15));
            if ($urandom_range(49) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                #1 check_all("rnd_rst");
                reset = 1'b0;
                #1;
            end
            tick();
            check_all("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 8: width of count and load_val.
REQ-002 Parameter STEP, default 1: increment/decrement applied per enabled cycle.
REQ-003 Parameter MAX_VAL, default 2**COUNTER_WIDTH-1: terminal value; the count range is 0..MAX_VAL.
REQ-004 Parameter SATURATE, default 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at bounds.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 clr  in  1  synchronous clear to 0.
REQ-008 load  in  1  synchronous load of load_val.
REQ-009 load_val  in  COUNTER_WIDTH  value to load.
REQ-010 cnt  in  1  count enable.
REQ-011 up  in  1  direction: 1 = up, 0 = down; sampled only when cnt=1.
REQ-012 count  out  COUNTER_WIDTH  registered count value.
REQ-013 tc  out  1  combinational terminal count: count==MAX_VAL when up=1, count==0 when up=0.
REQ-014 ovf  out  1  registered one-cycle pulse on a boundary crossing.
REQ-015 ovf_sticky  out  1  registered sticky overflow flag; present only with MOD_COUNTER_STICKY_EN.

Function
REQ-016 Priority per edge SHALL be clr > load > cnt; with none asserted, count holds.
REQ-017 load SHALL write min(load_val, MAX_VAL) to count, with no ovf.
REQ-018 Up, no crossing (count+STEP <= MAX_VAL): count SHALL become count+STEP.
REQ-019 Up crossing with SATURATE=0: count SHALL become count+STEP-(MAX_VAL+1).
REQ-020 Up crossing with SATURATE=1: count SHALL become MAX_VAL.
REQ-021 Down, no crossing (count >= STEP): count SHALL become count-STEP.
REQ-022 Down crossing with SATURATE=0: count SHALL become count+(MAX_VAL+1)-STEP.
REQ-023 Down crossing with SATURATE=1: count SHALL become 0.
REQ-024 Next-value arithmetic SHALL be computed in COUNTER_WIDTH+1 bits so that count+STEP never truncates.
REQ-025 ovf SHALL be 1 in the cycle after any crossing accepted under REQ-019, REQ-020, REQ-022 or REQ-023, including a saturated hold at a bound; otherwise ovf SHALL be 0.
REQ-026 clr or load asserted with cnt SHALL suppress counting and ovf for that edge.
REQ-027 Latency: count and ovf SHALL update one edge after the enabling input is sampled; tc follows count combinationally.
REQ-028 Parameter legality: 1 <= STEP <= MAX_VAL < 2**COUNTER_WIDTH; a violation SHALL be flagged at elaboration.

Reset
REQ-029 reset SHALL immediately force count=0, ovf=0 and ovf_sticky=0, independent of clk.
REQ-030 reset asserted mid-count SHALL discard any pending update; counting SHALL resume on the first edge after deassertion.

Configuration
REQ-031 With MOD_COUNTER_STICKY_EN defined: ovf_sticky SHALL set on the edge that raises ovf, hold until clr or reset, and clr SHALL take priority over a simultaneous set.
REQ-032 Without MOD_COUNTER_STICKY_EN: the ovf_sticky port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The direction encoding constants (DIR_UP=1, DIR_DOWN=0) and the mode constants (MODE_WRAP=0, MODE_SAT=1) SHALL live in shared package counter_pkg.
REQ-034 Next-value and crossing computation SHALL be a combinational sub-module mod_step; mod_counter holds the registers and priority logic.

Verification (COUNTER_WIDTH=4, MAX_VAL=9, STEP=3 unless noted)
REQ-035 Wrap up: load 8; cnt=1, up=1 for 2 edges -> count 1 then 4; ovf=1 after the first edge only.
REQ-036 Wrap down: load 1; cnt=1, up=0 -> count 8, ovf pulse; tc=1 at count 0 with up=0.
REQ-037 Saturate (SATURATE=1): load 8; count up 2 edges -> 9, 9; ovf=1 on both edges; tc=1.
REQ-038 Priority: clr=1, load=1 (load_val=5), cnt=1 together -> count 0; then load=1, cnt=1 -> count 5; load_val=15 -> count 9.
REQ-039 Async reset: assert reset between edges at count 7 -> count 0 before the next edge, ovf=0.
REQ-040 Sticky (macro defined): force a crossing -> ovf_sticky=1 and held for 10 idle edges; clr -> 0.
